// File: rtl/cpu_pkg.sv
// Types and widths shared by the fetch stage and its IF/ID output register.
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {BOOT, RUN, HALTED, FAULT} fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a new entry, flush drops valid but keeps the data.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);
  logic   valid_d, valid_q;
  if_id_t data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;
endmodule

// File: rtl/instr_fetch_stage.sv
// PC + fetch FSM in front of a combinational instruction memory, feeding an IF/ID register
// with redirect/flush, decode back-pressure, sticky halt and PC fault detection.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic        halted,
  output logic [31:0] fetch_count
);
  // 33 bits so a 2^30-word memory still has a representable limit.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_WORDS) * 33'd4;

  fetch_state_t state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  fetch_count_d, fetch_count_q;
  logic         fault_d, fault_q;
  logic         load, flush, accept, tgt_bad, pc_oob;
  if_id_t       ifid_d, ifid_q;

  assign accept  = !out_valid || out_ready;
  assign tgt_bad = (redirect_target[1:0] != 2'b00) || ({1'b0, redirect_target} >= MEM_LIMIT);
  assign pc_oob  = {1'b0, pc_q} >= MEM_LIMIT;
  assign ifid_d  = '{instr: imem_data, pc: pc_q, pc_plus4: pc_q + 32'd4};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    fault_d       = fault_q;
    load          = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (tgt_bad) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_target;
            if (halt_req) state_d = HALTED;
          end
        end else if (halt_req) begin
          state_d = HALTED;
        end else if (pc_oob) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (accept) begin
          load          = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      // Terminal states only let decode drain the held entry.
      HALTED, FAULT: flush = out_ready;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      fault_q       <= fault_d;
    end
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .flush (flush),
    .d     (ifid_d),
    .valid (out_valid),
    .q     (ifid_q)
  );

  assign imem_addr    = pc_q;
  assign out_instr    = ifid_q.instr;
  assign out_pc       = ifid_q.pc;
  assign out_pc_plus4 = ifid_q.pc_plus4;
  assign fault        = fault_q;
  assign halted       = (state_q == HALTED) || (state_q == FAULT);
  assign fetch_count  = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a cycle-level behavioural model.
module tb_instr_fetch_stage;
  localparam int MEM_WORDS = 16;
  localparam longint LIM = MEM_WORDS * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt_req = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, fault, halted;
  logic [31:0] out_instr, out_pc, out_pc_plus4, fetch_count;

  logic [31:0] mem [0:MEM_WORDS-1];

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 boot, 1 run, 2 halted, 3 fault
  int          m_st;
  logic [31:0] m_pc, m_instr, m_opc, m_opc4, m_cnt;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  assign imem_data = ({1'b0, imem_addr} < 33'(LIM)) ? mem[imem_addr[5:2]] : (32'hBAD0_0000 ^ imem_addr);

  instr_fetch_stage #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .fault(fault), .halted(halted), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem[a[5:2]];
  endfunction

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_opc4 = 0;
    m_cnt = 0; m_fault = 0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] tgt, input logic hr, input logic rdy);
    bit acc;
    acc = !m_valid || rdy;
    case (m_st)
      0: m_st = 1;
      1: begin
        if (rv) begin
          m_valid = 0;
          if (tgt % 4 != 0 || longint'(tgt) >= LIM) begin
            m_st = 3; m_fault = 1;
          end else begin
            m_pc = tgt;
            if (hr) m_st = 2;
          end
        end else if (hr) m_st = 2;
        else if (longint'(m_pc) >= LIM) begin
          m_st = 3; m_fault = 1;
        end else if (acc) begin
          m_instr = mem_at(m_pc); m_opc = m_pc; m_opc4 = m_pc + 32'd4; m_valid = 1;
          m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
      end
      default: if (rdy) m_valid = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".instr"}, out_instr, m_instr);
    chk({tag, ".pc"}, out_pc, m_opc);
    chk({tag, ".pc4"}, out_pc_plus4, m_opc4);
    chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
    chk({tag, ".halted"}, 32'(halted), 32'(m_st >= 2));
    chk({tag, ".count"}, fetch_count, m_cnt);
    chk({tag, ".addr"}, imem_addr, m_pc);
  endtask

  // Called #1 after a rising edge; asserts reset mid-cycle and checks before any edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic rv, input logic [31:0] tgt,
                     input logic hr, input logic rdy);
    redirect_valid = rv; redirect_target = tgt; halt_req = hr; out_ready = rdy;
    @(posedge clk);
    model_step(rv, tgt, hr, rdy);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    @(posedge clk); #1;
    do_reset("rst0");

    // boot bubble, then stream 0,4
    cyc("boot", 0, 0, 0, 1);
    chk("boot.bubble", 32'(out_valid), 32'h0);
    cyc("f0", 0, 0, 0, 1);
    chk("f0.pc", out_pc, 32'h0);
    chk("f0.instr", out_instr, 32'h11);
    cyc("f1", 0, 0, 0, 1);
    // back-pressure with out_pc=4
    for (int i = 0; i < 3; i++) begin
      cyc("bp", 0, 0, 0, 0);
      chk("bp.pc", out_pc, 32'h4);
      chk("bp.addr", imem_addr, 32'h8);
    end
    cyc("bp_rel", 0, 0, 0, 1);
    chk("bp_rel.pc", out_pc, 32'h8);
    cyc("f3", 0, 0, 0, 1);
    chk("f3.instr", out_instr, 32'h44);
    chk("f3.count", fetch_count, 32'd4);

    // redirect to 0x10 while valid
    cyc("redir", 1, 32'h10, 0, 1);
    chk("redir.flush", 32'(out_valid), 32'h0);
    cyc("redir2", 0, 0, 0, 1);
    chk("redir2.pc", out_pc, 32'h10);
    chk("redir2.instr", out_instr, mem[4]);

    // misaligned redirect, then ignored redirect
    cyc("mis", 1, 32'h6, 0, 1);
    chk("mis.fault", 32'(fault), 32'h1);
    chk("mis.addr", imem_addr, 32'h14);
    cyc("mis_ign", 1, 32'h20, 0, 1);
    chk("mis_ign.addr", imem_addr, 32'h14);

    // sequential run-off at the end of memory
    do_reset("rst1");
    cyc("ro_boot", 0, 0, 0, 1);
    cyc("ro_jump", 1, 32'(LIM - 8), 0, 1);
    for (int i = 0; i < 4; i++) cyc("ro", 0, 0, 0, 1);
    chk("ro.fault", 32'(fault), 32'h1);
    chk("ro.lastpc", out_pc, 32'(LIM - 4));

    // halt with a held instruction, then reset inside HALTED
    do_reset("rst2");
    cyc("h_boot", 0, 0, 0, 1);
    cyc("h_f0", 0, 0, 0, 0);
    cyc("h_req", 0, 0, 1, 0);
    chk("h.halted", 32'(halted), 32'h1);
    chk("h.held", 32'(out_valid), 32'h1);
    cyc("h_ign", 1, 32'h8, 0, 0);
    cyc("h_drain", 0, 0, 0, 1);
    chk("h.drained", 32'(out_valid), 32'h0);
    do_reset("rst_halt");

    // randomized episodes
    for (int e = 0; e < 25; e++) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      do_reset("rst_rnd");
      for (int c = 0; c < 150; c++) begin
        logic rv, hr, rdy;
        logic [31:0] tgt;
        int r;
        rv  = ($urandom_range(0, 11) == 0);
        hr  = ($urandom_range(0, 79) == 0);
        rdy = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 9);
        if (r < 7)       tgt = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
        else if (r == 7) tgt = ($urandom & 32'h3C) | 32'($urandom_range(1, 3));
        else if (r == 8) tgt = 32'(LIM) + 32'($urandom_range(0, 1000) * 4);
        else             tgt = 32'hFFFF_FFFC;
        cyc("rnd", rv, tgt, hr, rdy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- PC/fetch stage directly upstream of the combinational instruction memory: drives the word-aligned byte address and captures the returned 32-bit instruction.
- Registers the instruction, PC and PC+4 into an IF/ID output register with a valid/ready handshake toward decode.
- Supports branch redirect with flush, decode back-pressure, a halt request, and fault detection for misaligned or out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- MEM_WORDS, 32, instruction memory depth in 32-bit words; valid byte addresses are 0 .. MEM_WORDS*4-4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals pc at all times.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump taken; load redirect_target and flush.
- redirect_target  input  32  new PC (byte address).
- halt_req  input  1  stop fetching; sticky until reset.
- out_ready  input  1  decode can accept out_* this cycle.
- out_valid  output  1  out_instr, out_pc and out_pc_plus4 hold a live instruction.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  address the instruction was fetched from.
- out_pc_plus4  output  32  out_pc + 4 (mod 2^32).
- fault  output  1  sticky; set on a misaligned or out-of-range PC.
- halted  output  1  high in the HALTED or FAULT state.
- fetch_count  output  32  number of instructions loaded into the output register; wraps at 2^32.

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - pc=RESET_PC, state=BOOT.
  - out_valid=0; out_instr=0, out_pc=0, out_pc_plus4=0.
  - fault=0, halted=0, fetch_count=0.
- States:
  - BOOT: one bubble cycle, then RUN unconditionally.
  - RUN: normal fetch.
  - HALTED: no fetch.
  - FAULT: no fetch.
- Accept condition: accept = !out_valid || out_ready.
- RUN priority, highest first:
  1. redirect_valid=1:
     - out_valid<=0 (flush; any held or in-flight instruction is discarded).
     - If redirect_target[1:0]!=0 or redirect_target >= MEM_WORDS*4: state<=FAULT, fault<=1, pc unchanged.
     - Otherwise: pc<=redirect_target; no fetch this cycle.
     - If halt_req is also 1 and there is no fault: pc still loads the target, then state<=HALTED.
  2. halt_req=1: state<=HALTED; no new fetch; the output register is kept.
  3. pc >= MEM_WORDS*4 (sequential run-off): state<=FAULT, fault<=1; the output register is kept.
  4. accept=1 (fetch):
     - out_instr<=imem_data, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1.
     - pc<=pc+4.
     - fetch_count<=fetch_count+1.
  5. accept=0 (stall): pc and all out_* hold.
- Fetch latency: an instruction at address A appears on out_* the cycle after pc==A with accept=1. Throughput is 1 instruction/cycle when out_ready=1.
- HALTED and FAULT:
  - redirect_valid and halt_req are ignored.
  - A held out_valid=1 clears when out_ready=1; out_* data holds.
  - Both states are left only by reset.
- Width rules: pc+4 wraps modulo 2^32 before the range check. MEM_WORDS*4 is computed in 33 bits.
- imem_addr is combinational from pc and is never gated.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {BOOT, RUN, HALTED, FAULT}.
  - INSTR_W=32, ADDR_W=32.
  - IF/ID struct if_id_t {instr, pc, pc_plus4}.
- Natural sub-module: if_id_reg, the valid/ready output register holding if_id_t, with load, flush and hold controls.
- The PC and FSM remain in instr_fetch_stage.

Test Plan:
- Reset then run with out_ready=1 and memory words 0..3 = 32'h11,22,33,44:
  - BOOT bubble; out_valid rises at cycle 2.
  - out_pc sequence 0,4,8,12 with matching instructions.
  - fetch_count reaches 4.
- Back-pressure: out_ready=0 for 3 cycles while out_pc=4:
  - out_* hold at pc 4 and pc stays 8.
  - On release, out_pc=8 appears next cycle; no instruction is dropped or duplicated.
- Redirect: redirect_valid=1, target=32'h10 while out_valid=1:
  - Next cycle out_valid=0.
  - The following cycle out_pc=32'h10, out_instr=mem[4].
- Misaligned redirect to 32'h6:
  - Next cycle fault=1, halted=1, out_valid=0.
  - imem_addr unchanged; later redirects are ignored.
- Sequential run-off with MEM_WORDS=4:
  - After out_pc=12 is fetched, pc=16 triggers fault=1.
  - Pc=16 is never captured.
- halt_req with out_ready=0 and a held instruction, then asynchronous reset mid-HALTED:
  - While HALTED: halted=1; out_valid stays 1 until out_ready=1, then 0.
  - On reset: all outputs return to reset values immediately, without waiting for a clock edge.
